// File: rtl/first_nios2_system_sysid_checker_if.sv
// rtl/first_nios2_system_sysid_checker_if.sv - Avalon-MM read bus between the sysid checker and the sysid slave
interface first_nios2_system_sysid_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (output address, output read, input waitrequest, input readdata);
    modport slave  (input address, input read, output waitrequest, output readdata);
endinterface

// File: rtl/first_nios2_system_sysid_checker.sv
// rtl/first_nios2_system_sysid_checker.sv - reads sysid ID/timestamp and compares to build values; stall timeout under SYSID_CHECKER_TIMEOUT_EN
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1525092812,
    parameter int unsigned READ_LATENCY       = 0,
    parameter bit          AUTO_START         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       start,
    first_nios2_system_sysid_checker_if.master         avm,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       pass,
    output logic                                       id_match,
    output logic                                       ts_match,
    output logic                                       timeout,
    output logic [31:0]                                sysid_id,
    output logic [31:0]                                sysid_timestamp
);

    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

    localparam logic [1:0] LAT_LAST = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    state_t      state, state_nxt;
    logic        armed;
    logic [1:0]  lat_cnt;
    logic        trigger;
    logic        accept;
    logic        lat_last;
    logic        stall_abort;
    logic        capture_id;
    logic        capture_ts;
    logic        id_hit;
    logic        ts_hit;
    logic        finishing;

    assign trigger  = start | (armed & AUTO_START);
    assign accept   = avm.read & ~avm.waitrequest;
    assign lat_last = (lat_cnt == LAT_LAST);

    assign capture_id = ((state == RD_ID) && accept && (READ_LATENCY == 0)) ||
                        ((state == LAT_ID) && lat_last);
    assign capture_ts = ((state == RD_TS) && accept && (READ_LATENCY == 0)) ||
                        ((state == LAT_TS) && lat_last);

    // The ID word is already registered by the time the timestamp phase ends;
    // the timestamp is compared straight off the bus in its capture cycle.
    assign id_hit    = ((state == RD_TS) || (state == LAT_TS)) && (sysid_id == EXPECTED_ID);
    assign ts_hit    = capture_ts && (avm.readdata == EXPECTED_TIMESTAMP);
    assign finishing = (state_nxt == DONE) && (state != DONE);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] stall_cnt;

    always_ff @(posedge clock) begin
        if (reset || !avm.read || !avm.waitrequest) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_abort = avm.read & avm.waitrequest & (stall_cnt == STALL_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign stall_abort        = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        avm.read    = 1'b0;
        avm.address = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (trigger) state_nxt = RD_ID;
            end
            RD_ID: begin
                avm.read = 1'b1;
                if (stall_abort) begin
                    state_nxt = DONE;
                end else if (!avm.waitrequest) begin
                    state_nxt = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
                end
            end
            LAT_ID: begin
                if (lat_last) state_nxt = RD_TS;
            end
            RD_TS: begin
                avm.read    = 1'b1;
                avm.address = 1'b1;
                if (stall_abort) begin
                    state_nxt = DONE;
                end else if (!avm.waitrequest) begin
                    state_nxt = (READ_LATENCY == 0) ? DONE : LAT_TS;
                end
            end
            LAT_TS: begin
                avm.address = 1'b1;
                if (lat_last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            armed           <= 1'b1;
            lat_cnt         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            id_match        <= 1'b0;
            ts_match        <= 1'b0;
            timeout         <= 1'b0;
            sysid_id        <= '0;
            sysid_timestamp <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= ((state == LAT_ID) || (state == LAT_TS)) ? 2'(lat_cnt + 2'd1) : 2'd0;
            if (capture_id) sysid_id        <= avm.readdata;
            if (capture_ts) sysid_timestamp <= avm.readdata;
            if (((state == IDLE) || (state == DONE)) && trigger) begin
                armed    <= 1'b0;
                busy     <= 1'b1;
                done     <= 1'b0;
                pass     <= 1'b0;
                id_match <= 1'b0;
                ts_match <= 1'b0;
                timeout  <= 1'b0;
            end
            if (finishing) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                id_match <= id_hit;
                ts_match <= ts_hit;
                pass     <= id_hit & ts_hit & ~stall_abort;
                timeout  <= stall_abort;
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb/tb_first_nios2_system_sysid_checker.sv - randomized model-checked bench for the sysid checker (latency 0 and 2 instances)
`timescale 1ns/1ps
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1525092812;
    localparam int          TO_CYC = 8;
    localparam int          NI     = 2;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic start;

    logic [NI-1:0] busy_o, done_o, pass_o, idm_o, tsm_o, to_o, rd_o, ad_o;
    logic [31:0]   id_o [NI];
    logic [31:0]   ts_o [NI];
    logic [NI-1:0] wr_i;
    logic [31:0]   rdata_i [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    first_nios2_system_sysid_checker_if bus0 ();
    first_nios2_system_sysid_checker_if bus1 ();

    assign rd_o[0] = bus0.read;
    assign ad_o[0] = bus0.address;
    assign bus0.waitrequest = wr_i[0];
    assign bus0.readdata    = rdata_i[0];
    assign rd_o[1] = bus1.read;
    assign ad_o[1] = bus1.address;
    assign bus1.waitrequest = wr_i[1];
    assign bus1.readdata    = rdata_i[1];

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(0),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TO_CYC)
    ) u0 (
        .clock(clock), .reset(reset), .start(start), .avm(bus0.master),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .id_match(idm_o[0]),
        .ts_match(tsm_o[0]), .timeout(to_o[0]), .sysid_id(id_o[0]), .sysid_timestamp(ts_o[0])
    );

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(2),
        .AUTO_START(1'b1), .TIMEOUT_CYCLES(TO_CYC)
    ) u1 (
        .clock(clock), .reset(reset), .start(start), .avm(bus1.master),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .id_match(idm_o[1]),
        .ts_match(tsm_o[1]), .timeout(to_o[1]), .sysid_id(id_o[1]), .sysid_timestamp(ts_o[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d got=%0h want=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Slave: mem[k][addr]; wmode 0 none, 1 random stalls, 2 stuck; data is random unless valid
    int          wmode [NI];
    int          stall_budget [NI];
    logic [31:0] mem [NI][2];
    bit          acc_valid [NI];
    int          acc_cyc [NI];
    logic        acc_addr [NI];
    int          ncyc = 0;

    always @(negedge clock) begin
        #1;
        ncyc++;
        for (int k = 0; k < NI; k++) begin
            logic        w;
            logic [31:0] dat;
            w = (wmode[k] == 2) || (rd_o[k] && stall_budget[k] > 0) ||
                (wmode[k] == 1 && $urandom_range(2) == 0);
            if (rd_o[k] && stall_budget[k] > 0) stall_budget[k]--;
            dat = $urandom;
            if (lat_of(k) == 0) begin
                if (rd_o[k] && !w) dat = mem[k][ad_o[k]];
            end else if (acc_valid[k] && acc_cyc[k] == ncyc - lat_of(k)) begin
                dat = mem[k][acc_addr[k]];
            end
            if (rd_o[k] && !w) begin
                acc_valid[k] = 1'b1;
                acc_cyc[k]   = ncyc;
                acc_addr[k]  = ad_o[k];
            end
            wr_i[k]    = w;
            rdata_i[k] = dat;
        end
    end

    // Transaction-level model: a check is two word fetches, each waiting out
    // its stalls and then the read latency before the word is known.
    bit          m_busy [NI], m_done [NI], m_pass [NI], m_idm [NI], m_tsm [NI], m_to [NI];
    logic [31:0] m_id [NI], m_ts [NI];
    bit          m_active [NI], m_armed [NI];
    int          m_word [NI], m_lat [NI], m_stall [NI];

    task automatic m_finish(input int k, input bit aborted);
        m_active[k] = 1'b0;
        m_busy[k]   = 1'b0;
        m_done[k]   = 1'b1;
        m_to[k]     = aborted;
        m_idm[k]    = (m_word[k] == 1) && (m_id[k] == EXP_ID);
        m_tsm[k]    = !aborted && (m_ts[k] == EXP_TS);
        m_pass[k]   = m_idm[k] && m_tsm[k] && !aborted;
    endtask

    task automatic m_take(input int k, input logic [31:0] d);
        if (m_word[k] == 0) begin
            m_id[k]   = d;
            m_word[k] = 1;
            m_lat[k]  = -1;
            m_stall[k] = 0;
        end else begin
            m_ts[k] = d;
            m_finish(k, 1'b0);
        end
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_busy[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_idm[k] = 0; m_tsm[k] = 0; m_to[k] = 0;
                m_id[k] = '0; m_ts[k] = '0; m_active[k] = 0; m_armed[k] = 1; m_lat[k] = -1;
                m_word[k] = 0; m_stall[k] = 0;
            end else if (!m_active[k]) begin
                if (start || m_armed[k]) begin
                    m_armed[k] = 0; m_active[k] = 1; m_word[k] = 0; m_lat[k] = -1; m_stall[k] = 0;
                    m_busy[k] = 1; m_done[k] = 0; m_pass[k] = 0; m_idm[k] = 0; m_tsm[k] = 0; m_to[k] = 0;
                end
            end else if (m_lat[k] < 0) begin
                if (wr_i[k]) begin
                    m_stall[k]++;
                    if (TO_ON && m_stall[k] == TO_CYC) m_finish(k, 1'b1);
                end else if (lat_of(k) == 0) begin
                    m_take(k, rdata_i[k]);
                end else begin
                    m_lat[k] = lat_of(k);
                end
            end else begin
                m_lat[k]--;
                if (m_lat[k] == 0) m_take(k, rdata_i[k]);
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            logic m_rd;
            m_rd = m_active[k] && (m_lat[k] < 0);
            check("busy", k, busy_o[k], m_busy[k]);
            check("done", k, done_o[k], m_done[k]);
            check("pass", k, pass_o[k], m_pass[k]);
            check("id_match", k, idm_o[k], m_idm[k]);
            check("ts_match", k, tsm_o[k], m_tsm[k]);
            check("timeout", k, to_o[k], m_to[k]);
            check("sysid_id", k, id_o[k], m_id[k]);
            check("sysid_timestamp", k, ts_o[k], m_ts[k]);
            check("avm_read", k, rd_o[k], m_rd);
            if (m_rd) check("avm_address", k, ad_o[k], m_word[k][0]);
        end
    end

    task automatic restore_mem();
        for (int k = 0; k < NI; k++) begin
            mem[k][0] = EXP_ID;
            mem[k][1] = EXP_TS;
        end
    endtask

    initial begin
        int cnt_id;
        int first_done [NI];
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < NI; k++) begin
            wmode[k] = 0; stall_budget[k] = 0; acc_valid[k] = 0; acc_cyc[k] = 0; acc_addr[k] = 0;
            wr_i[k] = 1'b0; rdata_i[k] = '0;
        end
        restore_mem();

        // auto-start after reset release; this negedge is in cycle 0
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t1_c1_read", 0, rd_o[0], 1'b1);
        check("t1_c1_addr", 0, ad_o[0], 1'b0);
        check("t1_c1_read", 1, rd_o[1], 1'b1);
        @(negedge clock);
        check("t1_c2_read", 0, rd_o[0], 1'b1);
        check("t1_c2_addr", 0, ad_o[0], 1'b1);
        check("t1_c2_read", 1, rd_o[1], 1'b0);
        @(negedge clock);
        check("t1_c3_done", 0, done_o[0], 1'b1);
        check("t1_c3_pass", 0, pass_o[0], 1'b1);
        check("t1_c3_ts", 0, ts_o[0], 32'd1525092812);
        repeat (3) @(negedge clock);
        check("t5_c6_done", 1, done_o[1], 1'b0);
        @(negedge clock);
        check("t5_c7_done", 1, done_o[1], 1'b1);
        check("t5_c7_pass", 1, pass_o[1], 1'b1);
        check("t5_c7_ts", 1, ts_o[1], 32'd1525092812);

        // timestamp mismatch
        @(negedge clock);
        for (int k = 0; k < NI; k++) mem[k][1] = 32'd1525092813;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            check("t2_done", k, done_o[k], 1'b1);
            check("t2_id_match", k, idm_o[k], 1'b1);
            check("t2_ts_match", k, tsm_o[k], 1'b0);
            check("t2_pass", k, pass_o[k], 1'b0);
            check("t2_ts", k, ts_o[k], 32'd1525092813);
        end

        // three stall cycles on the ID read
        @(negedge clock);
        restore_mem();
        for (int k = 0; k < NI; k++) begin
            stall_budget[k] = 3;
            first_done[k]   = 0;
        end
        start  = 1'b1;
        cnt_id = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clock);
            if (j == 1) start = 1'b0;
            if (rd_o[0] && !ad_o[0]) cnt_id++;
            for (int k = 0; k < NI; k++)
                if (done_o[k] && first_done[k] == 0) first_done[k] = j;
        end
        check("t3_id_read_cycles", 0, cnt_id, 4);
        check("t3_done_cycle", 0, first_done[0], 6);
        check("t3_done_cycle", 1, first_done[1], 10);
        check("t3_pass", 0, pass_o[0], 1'b1);

        // stuck waitrequest
        @(negedge clock);
        for (int k = 0; k < NI; k++) wmode[k] = 2;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (1000) @(negedge clock);
`ifdef SYSID_CHECKER_TIMEOUT_EN
        check("t4_timeout", 0, to_o[0], 1'b1);
        check("t4_done", 0, done_o[0], 1'b1);
        check("t4_pass", 0, pass_o[0], 1'b0);
        check("t4_read", 0, rd_o[0], 1'b0);
`else
        check("t4_read", 0, rd_o[0], 1'b1);
        check("t4_busy", 0, busy_o[0], 1'b1);
        check("t4_done", 0, done_o[0], 1'b0);
`endif
        for (int k = 0; k < NI; k++) wmode[k] = 0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);

        // start while busy, then reset during the timestamp latency of u1
        start = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clock);
            start = (j == 2);
            if (j == 5) begin
                check("t6_mid_busy", 1, busy_o[1], 1'b1);
                check("t6_mid_read", 1, rd_o[1], 1'b0);
                reset = 1'b1;
            end
        end
        for (int k = 0; k < NI; k++) begin
            check("t6_rst_busy", k, busy_o[k], 1'b0);
            check("t6_rst_done", k, done_o[k], 1'b0);
            check("t6_rst_read", k, rd_o[k], 1'b0);
            check("t6_rst_id", k, id_o[k], 32'd0);
            check("t6_rst_ts", k, ts_o[k], 32'd0);
        end
        reset = 1'b0;
        repeat (8) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            check("t6_auto_done", k, done_o[k], 1'b1);
            check("t6_auto_pass", k, pass_o[k], 1'b1);
        end

        // randomized phase
        for (int k = 0; k < NI; k++) wmode[k] = 1;
        for (int it = 0; it < 60; it++) begin
            int r;
            @(negedge clock);
            if (!m_active[0] && !m_active[1]) begin
                for (int k = 0; k < NI; k++) begin
                    mem[k][0] = ($urandom_range(3) == 0) ? $urandom : EXP_ID;
                    mem[k][1] = ($urandom_range(3) == 0) ? $urandom : EXP_TS;
                end
            end
            r = $urandom_range(9);
            start = (r < 6);
            reset = (r == 9);
            @(negedge clock);
            start = 1'b0;
            reset = 1'b0;
            repeat ($urandom_range(14, 1)) @(negedge clock);
        end
        for (int k = 0; k < NI; k++) wmode[k] = 0;
        repeat (30) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
